// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns PC, IR, multi-cycle State and N/Z flags, and absorbs imem wait states.
// Optional performance counters are enabled by defining FETCH_PERF_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter logic [15:0] NOP_WORD     = 16'h0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_ps,
  input  logic        i_ir_l,
  input  logic        i_ns,
  input  logic [15:0] i_jump_target,
  input  logic        i_alu_n,
  input  logic        i_alu_z,
  input  logic        i_flag_we,
  input  logic [15:0] i_imem_data,
  input  logic        i_imem_valid,
  output logic [15:0] o_imem_addr,
  output logic [15:0] o_pc,
  output logic [15:0] o_ir,
  output logic        o_state,
  output logic        o_n_flag,
  output logic        o_z_flag,
  output logic        o_stall
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_retired_count,
  output logic [31:0] o_stall_count
`endif
);

  localparam logic [0:0] BOOT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]  r_fsm;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic        r_state;
  logic        r_n;
  logic        r_z;

  logic [15:0] w_next_pc;
  logic        w_stall;
  logic        w_retire;

  // In BOOT the decoder is not trusted yet, so the fetch address stays on the current PC.
  always_comb begin
    w_next_pc = r_pc;
    if (r_fsm == RUN) begin
      case (i_ps)
        2'b00:   w_next_pc = r_pc;
        2'b01:   w_next_pc = r_pc + 16'd1;
        2'b10:   w_next_pc = i_jump_target;
        default: w_next_pc = r_pc + {{8{r_ir[7]}}, r_ir[7:0]};
      endcase
    end
  end

  assign w_stall  = (r_fsm == BOOT) ? ~i_imem_valid : (i_ir_l & ~i_imem_valid);
  assign w_retire = (r_fsm == RUN) & ~w_stall & i_ir_l;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fsm   <= BOOT;
      r_pc    <= RESET_VECTOR;
      r_ir    <= NOP_WORD;
      r_state <= 1'b0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
    end else if (r_fsm == BOOT) begin
      if (i_imem_valid) begin
        r_ir  <= i_imem_data;
        r_fsm <= RUN;
      end
    end else if (!w_stall) begin
      r_pc    <= w_next_pc;
      r_state <= i_ns;
      if (i_ir_l) begin
        r_ir <= i_imem_data;
      end
      if (i_flag_we) begin
        r_n <= i_alu_n;
        r_z <= i_alu_z;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_retired_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_retired_count <= 32'd0;
      r_stall_count   <= 32'd0;
    end else begin
      if (w_retire) begin
        r_retired_count <= r_retired_count + 32'd1;
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign o_retired_count = r_retired_count;
  assign o_stall_count   = r_stall_count;
`else
  // Default build carries no counters; the retire strobe is left unobserved.
  logic w_unused;
  assign w_unused = w_retire;
`endif

  assign o_imem_addr = w_next_pc;
  assign o_pc        = r_pc;
  assign o_ir        = r_ir;
  assign o_state     = r_state;
  assign o_n_flag    = r_n;
  assign o_z_flag    = r_z;
  assign o_stall     = w_stall;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed vectors push hand-computed expectations,
// a monitor checks combinational outputs before each edge and registered state after it.
module tb_fetch_sequencer;

  logic        clk;
  logic        rstN;
  logic [1:0]  ps;
  logic        irL;
  logic        ns;
  logic [15:0] jumpTarget;
  logic        aluN;
  logic        aluZ;
  logic        flagWe;
  logic [15:0] imemData;
  logic        imemValid;
  logic [15:0] imemAddr;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        state;
  logic        nFlag;
  logic        zFlag;
  logic        stall;
`ifdef FETCH_PERF_EN
  logic [31:0] retiredCount;
  logic [31:0] stallCount;
`endif

  logic [15:0] mem [0:65535];

  typedef struct {
    logic [15:0] addr;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] ir;
    logic        st;
    logic        n;
    logic        z;
    logic [31:0] ret;
    logic [31:0] stc;
  } expT;

  expT expQ[$];
  int  errors = 0;
  int  checks = 0;

  fetch_sequencer dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_ps          (ps),
    .i_ir_l        (irL),
    .i_ns          (ns),
    .i_jump_target (jumpTarget),
    .i_alu_n       (aluN),
    .i_alu_z       (aluZ),
    .i_flag_we     (flagWe),
    .i_imem_data   (imemData),
    .i_imem_valid  (imemValid),
    .o_imem_addr   (imemAddr),
    .o_pc          (pc),
    .o_ir          (ir),
    .o_state       (state),
    .o_n_flag      (nFlag),
    .o_z_flag      (zFlag),
    .o_stall       (stall)
`ifdef FETCH_PERF_EN
    ,
    .o_retired_count (retiredCount),
    .o_stall_count   (stallCount)
`endif
  );

  assign imemData = mem[imemAddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs at the falling edge and records what the DUT must show.
  task automatic applyStimulus(
    input logic rst, input logic valid, input logic [1:0] psIn, input logic irlIn,
    input logic nsIn, input logic fweIn, input logic anIn, input logic azIn,
    input logic [15:0] jtIn, input logic [15:0] eAddr, input logic eStall,
    input logic [15:0] ePc, input logic [15:0] eIr, input logic eSt,
    input logic eN, input logic eZ, input logic [31:0] eRet, input logic [31:0] eStc);
    expT e;
    @(negedge clk);
    rstN       = rst;
    imemValid  = valid;
    ps         = psIn;
    irL        = irlIn;
    ns         = nsIn;
    flagWe     = fweIn;
    aluN       = anIn;
    aluZ       = azIn;
    jumpTarget = jtIn;
    e.addr = eAddr; e.stall = eStall; e.pc = ePc; e.ir = eIr;
    e.st = eSt; e.n = eN; e.z = eZ; e.ret = eRet; e.stc = eStc;
    expQ.push_back(e);
  endtask

  // Monitor: combinational outputs settle after the falling-edge drive, registers after the rising edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ[0];
        checkOutput("imem_addr", 32'(imemAddr), 32'(e.addr));
        checkOutput("stall", 32'(stall), 32'(e.stall));
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput("pc", 32'(pc), 32'(e.pc));
        checkOutput("ir", 32'(ir), 32'(e.ir));
        checkOutput("state", 32'(state), 32'(e.st));
        checkOutput("n_flag", 32'(nFlag), 32'(e.n));
        checkOutput("z_flag", 32'(zFlag), 32'(e.z));
`ifdef FETCH_PERF_EN
        checkOutput("retired_count", retiredCount, e.ret);
        checkOutput("stall_count", stallCount, e.stc);
`endif
      end
    end
  end

  initial begin
    int waitCycles;
    for (int a = 0; a < 65536; a++) mem[a] = 16'hDEAD;
    mem[16'h0000] = 16'hA105;
    mem[16'h0001] = 16'h1111;
    mem[16'h0002] = 16'h2222;
    mem[16'h0003] = 16'h3333;
    mem[16'h0004] = 16'h4444;
    mem[16'h0008] = 16'h8888;
    mem[16'h0010] = 16'h77F8;
    mem[16'hFFFE] = 16'h0005;
    mem[16'hFFFF] = 16'hF0F0;
    rstN = 1'b1; imemValid = 1'b0; ps = 2'b00; irL = 1'b0; ns = 1'b0;
    flagWe = 1'b0; aluN = 1'b0; aluZ = 1'b0; jumpTarget = 16'h0000;
    #1 rstN = 1'b0;

    //            rst v  ps     irl ns fwe an az jt        addr      stl pc        ir        st n  z  ret  stc
    applyStimulus(0, 0, 2'b00, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0,  0);
    applyStimulus(1, 0, 2'b00, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0,  1);
    applyStimulus(1, 1, 2'b01, 1, 1, 1, 1, 1, 16'h0000, 16'h0000, 0, 16'h0000, 16'hA105, 0, 0, 0, 0,  1);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h1111, 0, 0, 0, 1,  1);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0002, 0, 16'h0002, 16'h2222, 0, 0, 0, 2,  1);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0003, 0, 16'h0003, 16'h3333, 0, 0, 0, 3,  1);
    applyStimulus(1, 1, 2'b10, 1, 0, 0, 0, 0, 16'h0010, 16'h0010, 0, 16'h0010, 16'h77F8, 0, 0, 0, 4,  1);
    applyStimulus(1, 1, 2'b11, 1, 0, 0, 0, 0, 16'h0000, 16'h0008, 0, 16'h0008, 16'h8888, 0, 0, 0, 5,  1);
    applyStimulus(1, 1, 2'b10, 1, 0, 0, 0, 0, 16'hFFFE, 16'hFFFE, 0, 16'hFFFE, 16'h0005, 0, 0, 0, 6,  1);
    applyStimulus(1, 1, 2'b11, 1, 0, 0, 0, 0, 16'h0000, 16'h0003, 0, 16'h0003, 16'h3333, 0, 0, 0, 7,  1);
    applyStimulus(1, 1, 2'b10, 1, 0, 0, 0, 0, 16'hFFFF, 16'hFFFF, 0, 16'hFFFF, 16'hF0F0, 0, 0, 0, 8,  1);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'hA105, 0, 0, 0, 9,  1);
    applyStimulus(1, 0, 2'b00, 0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'hA105, 1, 0, 0, 9,  1);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0001, 0, 16'h0001, 16'h1111, 0, 0, 0, 10, 1);
    applyStimulus(1, 0, 2'b01, 1, 1, 1, 0, 1, 16'h0000, 16'h0002, 1, 16'h0001, 16'h1111, 0, 0, 0, 10, 2);
    applyStimulus(1, 0, 2'b01, 1, 1, 1, 0, 1, 16'h0000, 16'h0002, 1, 16'h0001, 16'h1111, 0, 0, 0, 10, 3);
    applyStimulus(1, 1, 2'b01, 1, 0, 1, 0, 1, 16'h0000, 16'h0002, 0, 16'h0002, 16'h2222, 0, 0, 1, 11, 3);
    applyStimulus(1, 1, 2'b00, 0, 0, 1, 1, 0, 16'h0000, 16'h0002, 0, 16'h0002, 16'h2222, 0, 1, 0, 11, 3);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 1, 16'h0000, 16'h0003, 0, 16'h0003, 16'h3333, 0, 1, 0, 12, 3);
    applyStimulus(1, 0, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0004, 1, 16'h0003, 16'h3333, 0, 1, 0, 12, 4);
    applyStimulus(0, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 0,  0);
    applyStimulus(1, 1, 2'b01, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'hA105, 0, 0, 0, 0,  0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Owns the program counter, instruction register, multi-cycle State bit and N/Z status flags; the other end of the instruction decoder interface.
- Supplies IR, State, N and Z to the decoder and consumes its PS, IR_L and NS outputs.
- Drives the instruction-memory address and absorbs memory wait states.
- Sits between instruction memory and the decoder/datapath.

Parameters:
RESET_VECTOR, 16'h0000, PC value loaded at reset
NOP_WORD, 16'h0000, IR value held from reset until the first fetch

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
ps  in  2  PC select from decoder: 00 hold, 01 increment, 10 jump absolute, 11 branch relative
ir_l  in  1  load IR this cycle
ns  in  1  next multi-cycle State from decoder
jump_target  in  16  absolute target for ps=10, from datapath
alu_n  in  1  ALU negative result
alu_z  in  1  ALU zero result
flag_we  in  1  update N/Z this cycle
imem_data  in  16  instruction word at imem_addr, combinational read
imem_valid  in  1  imem_data valid this cycle
imem_addr  out  16  fetch address (= next_pc)
pc  out  16  address of instruction currently in IR
ir  out  16  instruction register, to decoder IR
state  out  1  to decoder State
n_flag  out  1  to decoder N
z_flag  out  1  to decoder Z
stall  out  1  fetch waiting on memory; datapath must suppress register and memory writes

Behaviour:
- Async reset (rst_n=0):
  - pc=RESET_VECTOR, ir=NOP_WORD, state=0, n_flag=0, z_flag=0.
  - FSM=BOOT.
- FSM states BOOT, RUN.
- BOOT:
  - next_pc=pc; decoder inputs are ignored.
  - If imem_valid=1: ir<=imem_data, FSM<=RUN.
  - Otherwise stay in BOOT with stall=1.
- RUN, next_pc is combinational from ps:
  - 00: pc
  - 01: pc+1
  - 10: jump_target
  - 11: pc + sign_extend(ir[7:0])
- imem_addr=next_pc in all states (BOOT: pc).
- All PC arithmetic is modulo 2^16: FFFF+1=0000; 0002 + sext(8'hFC)=FFFE.
- stall = (FSM==BOOT & ~imem_valid) | (FSM==RUN & ir_l & ~imem_valid).
- RUN edge with stall=0:
  - pc<=next_pc; state<=ns.
  - If ir_l=1: ir<=imem_data.
  - If flag_we=1: n_flag<=alu_n, z_flag<=alu_z.
- RUN edge with stall=1:
  - pc, ir, state, n_flag and z_flag all hold.
  - The instruction re-presents next cycle, so its flag update happens exactly once.
- ir_l=0: ir holds (multi-cycle instructions). pc still follows ps; the decoder drives ps=00 for holds.
- Simultaneous flag_we and a branch: the branch decision uses the pre-edge flags; new flags are visible the next cycle.
- Latency: a branch or jump taken in cycle t has the target instruction in ir at t+1 (zero bubbles, combinational memory).
- Reset mid-operation or mid-stall: immediate return to BOOT with reset values; any pending fetch is abandoned.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined:
  - Adds output retired_count [31:0], reset 0.
  - Increments on each RUN edge with stall=0 and ir_l=1.
  - Wraps FFFFFFFF->0.
  - Adds output stall_count [31:0], reset 0, incrementing on every cycle with stall=1.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Test Plan:
- Reset release, imem_valid=1, mem[0000]=16'hA105 → one cycle later ir=A105, pc=0000, state=0, stall=0.
- Straight line: ps=01, ir_l=1 for 3 cycles, mem[1..3]=1111/2222/3333 → ir=1111,2222,3333; pc=0001,0002,0003; imem_addr leads pc by one.
- Branch relative: pc=0010, ir[7:0]=F8, ps=11, ir_l=1 → imem_addr=0008, next ir=mem[0008], pc=0008. Second run with pc=FFFE, ir[7:0]=05, ps=11 → pc=0003.
- Jump and wrap: ps=10, jump_target=FFFF → pc=FFFF; then ps=01 → pc=0000.
- Multi-cycle: ir_l=0, ps=00, ns=1 → ir, pc hold and state=1; next cycle ns=0, ir_l=1, ps=01 → state=0, new ir loaded.
- Stall and flags: ir_l=1, imem_valid=0 for 2 cycles with flag_we=1, alu_z=1 → stall=1, pc/ir/z_flag unchanged. Valid on 3rd cycle → z_flag=1 exactly once, ir loaded. With FETCH_PERF_EN, stall_count=2 and retired_count increments by 1.
